bait_depth_ctrl: RTL and testbench
==================================

// Module: bait_depth_ctrl
// PURPOSE
//   Produces the bait vertical position (mouse_v, units of 0.1 px) consumed by
//   the bait sprite renderer, which draws at row mouse_v/10, col 256..262.
//   Integrates mouse Y motion and commits it once per frame.
//   Runs a reel-in sequence on button press or fish catch.
//   Sits between the PS/2 mouse decoder and the sprite/pixel mux.
// PARAMETERS
//   GAIN        10    scaled units added per mouse count (1 count = 1 px)
//   MIN_V       720   top clamp of mouse_v (row 72, water surface)
//   MAX_V       4650  bottom clamp (row 465; sprite bottom row 479)
//   REEL_STEP   40    mouse_v decrement per frame while reeling (4 px/frame)
//   ACC_MAX     8000  saturation magnitude of the pending accumulator
//   LAND_FRAMES 30    frames spent in LANDED before control returns
// PORTS
//   clk          in   1   system clock
//   rst_n        in   1   asynchronous active-low reset
//   mouse_valid  in   1   1-cycle strobe: new mouse_dy is valid
//   mouse_dy     in   9   signed 2's-compl Y delta, positive = bait moves down
//   reel_btn     in   1   level; reel request (rising edge detected internally)
//   catch_evt    in   1   1-cycle pulse: fish hooked, forces reel
//   frame_tick   in   1   1-cycle pulse at start of vertical blank
//   mouse_v      out  14  bait position, 0.1 px units, always in [MIN_V,MAX_V]
//   st           out  2   state: 0 FREE, 1 REEL, 2 LANDED
//   hooked       out  1   1 while the current reel was caused by catch_evt
//   landed       out  1   1-cycle pulse on REEL->LANDED transition
// BEHAVIOUR
//   Reset (async, rst_n=0): mouse_v=MIN_V, st=FREE, pending acc=0, hooked=0,
//     landed=0, land_cnt=0, reel_btn edge register=0. All outputs registered.
//   FREE:
//     - mouse_valid: acc <= sat(acc + sext(mouse_dy)*GAIN, +/-ACC_MAX).
//     - frame_tick: mouse_v <= clamp(mouse_v + acc, MIN_V, MAX_V); acc <= 0.
//       With mouse_valid in the same cycle: acc <= that delta only (not lost).
//       Sum is computed in >=17-bit signed; clamp is applied before truncation.
//     - reel_btn rising edge -> REEL, hooked=0; acc cleared.
//     - catch_evt -> REEL, hooked=1; acc cleared.
//     - Reel trigger and frame_tick in the same cycle: the trigger wins and
//       the pending commit is discarded.
//     - mouse_v changes only on frame_tick, one cycle after the tick edge
//       (glitch-free across the visible frame).
//   REEL:
//     - mouse_valid ignored; acc held at 0.
//     - catch_evt sets hooked=1 (a reel in progress becomes a catch reel).
//     - frame_tick: mouse_v <= max(mouse_v - REEL_STEP, MIN_V).
//     - When the updated value equals MIN_V: st <= LANDED; landed=1 for one
//       cycle; land_cnt <= 0.
//     - Entered with mouse_v already == MIN_V: lands on the first frame_tick.
//   LANDED:
//     - mouse_v held at MIN_V; mouse input and reel_btn ignored.
//     - land_cnt increments on each frame_tick.
//     - At land_cnt == LAND_FRAMES-1 on a tick: st <= FREE, hooked <= 0, acc=0.
//   catch_evt in REEL or LANDED does not restart the sequence.
//   Mid-operation reset returns everything to reset values immediately.
// TESTING
//   1 Reset released, no input -> mouse_v=720, st=0, hooked=0, landed=0.
//   2 FREE: 3 strobes dy=+5, then frame_tick -> mouse_v=870 one cycle after
//     the tick; unchanged before the tick.
//   3 Clamp: dy=+255 x4 then tick -> mouse_v=4650; dy=-256 x4 then tick -> 720.
//   4 mouse_valid dy=+2 coincident with frame_tick after acc=+30
//     -> mouse_v += 30; next tick adds 20.
//   5 mouse_v=900, catch_evt -> st=1, hooked=1; ticks: 860,820,780,740,720;
//     landed pulses once at 720; st=2.
//   6 LANDED: 30 frame_ticks -> st=0, hooked=0; mouse moves resume; rst_n
//     pulsed mid-REEL -> mouse_v=720, st=0 immediately.

Source files
------------

// File: rtl/bait_depth_ctrl.sv
// Bait vertical position controller: integrates mouse Y motion, commits once
// per frame, and runs the reel-in / landed sequence on button press or catch.
module bait_depth_ctrl #(
  parameter int unsigned GAIN        = 10,
  parameter int unsigned MIN_V       = 720,
  parameter int unsigned MAX_V       = 4650,
  parameter int unsigned REEL_STEP   = 40,
  parameter int unsigned ACC_MAX     = 8000,
  parameter int unsigned LAND_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mouse_valid,
  input  logic [8:0]  mouse_dy,
  input  logic        reel_btn,
  input  logic        catch_evt,
  input  logic        frame_tick,
  output logic [13:0] mouse_v,
  output logic [1:0]  st,
  output logic        hooked,
  output logic        landed
);

  localparam int unsigned CntW = (LAND_FRAMES > 2) ? $clog2(LAND_FRAMES) : 1;

  localparam logic signed [16:0] GainS   = 17'(GAIN);
  localparam logic signed [16:0] AccMaxS = 17'(ACC_MAX);
  localparam logic signed [16:0] MinS    = 17'(MIN_V);
  localparam logic signed [16:0] MaxS    = 17'(MAX_V);
  localparam logic [13:0]        MinV    = 14'(MIN_V);
  localparam logic [13:0]        ReelLim = 14'(MIN_V + REEL_STEP);
  localparam logic [13:0]        Step    = 14'(REEL_STEP);
  localparam logic [CntW-1:0]    CntLast = CntW'(LAND_FRAMES - 1);

  typedef enum logic [1:0] {StFree = 2'd0, StReel = 2'd1, StLanded = 2'd2} state_e;

  state_e                st_q, st_d;
  logic [13:0]           mouse_v_q, mouse_v_d;
  logic signed [14:0]    acc_q, acc_d;
  logic                  hooked_q, hooked_d;
  logic                  landed_q, landed_d;
  logic [CntW-1:0]       land_cnt_q, land_cnt_d;
  logic                  btn_q;

  logic                  btn_rise;
  logic signed [16:0]    delta, acc_sum, pos_sum;
  logic [13:0]           reel_v;

  assign btn_rise = reel_btn & ~btn_q;
  assign delta    = 17'(signed'(mouse_dy)) * GainS;
  assign acc_sum  = 17'(acc_q) + delta;
  assign pos_sum  = signed'({3'b000, mouse_v_q}) + 17'(acc_q);
  assign reel_v   = (mouse_v_q >= ReelLim) ? (mouse_v_q - Step) : MinV;

  always_comb begin
    st_d       = st_q;
    mouse_v_d  = mouse_v_q;
    acc_d      = acc_q;
    hooked_d   = hooked_q;
    landed_d   = 1'b0;
    land_cnt_d = land_cnt_q;
    unique case (st_q)
      StFree: begin
        if (btn_rise || catch_evt) begin
          // Trigger wins over a coincident frame commit; pending motion is dropped.
          st_d     = StReel;
          hooked_d = catch_evt;
          acc_d    = '0;
        end else begin
          if (frame_tick) begin
            if (pos_sum < MinS)      mouse_v_d = MinV;
            else if (pos_sum > MaxS) mouse_v_d = 14'(MAX_V);
            else                     mouse_v_d = pos_sum[13:0];
            acc_d = mouse_valid ? delta[14:0] : '0;
          end else if (mouse_valid) begin
            if (acc_sum > AccMaxS)       acc_d = AccMaxS[14:0];
            else if (acc_sum < -AccMaxS) acc_d = 15'(-AccMaxS);
            else                         acc_d = acc_sum[14:0];
          end
        end
      end
      StReel: begin
        acc_d = '0;
        if (catch_evt) hooked_d = 1'b1;
        if (frame_tick) begin
          mouse_v_d = reel_v;
          if (reel_v == MinV) begin
            st_d       = StLanded;
            landed_d   = 1'b1;
            land_cnt_d = '0;
          end
        end
      end
      StLanded: begin
        acc_d     = '0;
        mouse_v_d = MinV;
        if (frame_tick) begin
          if (land_cnt_q == CntLast) begin
            st_d     = StFree;
            hooked_d = 1'b0;
          end else begin
            land_cnt_d = land_cnt_q + 1'b1;
          end
        end
      end
      default: st_d = StFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= StFree;
      mouse_v_q  <= MinV;
      acc_q      <= '0;
      hooked_q   <= 1'b0;
      landed_q   <= 1'b0;
      land_cnt_q <= '0;
      btn_q      <= 1'b0;
    end else begin
      st_q       <= st_d;
      mouse_v_q  <= mouse_v_d;
      acc_q      <= acc_d;
      hooked_q   <= hooked_d;
      landed_q   <= landed_d;
      land_cnt_q <= land_cnt_d;
      btn_q      <= reel_btn;
    end
  end

  assign mouse_v = mouse_v_q;
  assign st      = st_q;
  assign hooked  = hooked_q;
  assign landed  = landed_q;

endmodule

// File: tb/tb_bait_depth_ctrl.sv
// Directed bench for bait_depth_ctrl with hand-computed expected values.
module tb_bait_depth_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mouse_valid = 1'b0;
  logic [8:0]  mouse_dy = '0;
  logic        reel_btn = 1'b0;
  logic        catch_evt = 1'b0;
  logic        frame_tick = 1'b0;
  logic [13:0] mouse_v;
  logic [1:0]  st;
  logic        hooked;
  logic        landed;

  int n_cmp = 0;
  int n_bad = 0;

  bait_depth_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mouse_valid(mouse_valid),
    .mouse_dy   (mouse_dy),
    .reel_btn   (reel_btn),
    .catch_evt  (catch_evt),
    .frame_tick (frame_tick),
    .mouse_v    (mouse_v),
    .st         (st),
    .hooked     (hooked),
    .landed     (landed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int dy);
    mouse_valid = 1'b1;
    mouse_dy    = 9'(dy);
    step();
    mouse_valid = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  int exp_v [5] = '{860, 820, 780, 740, 720};

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    step();
    // Reset state
    check("rst_v", mouse_v, 720);
    check("rst_st", st, 0);
    check("rst_hooked", hooked, 0);
    check("rst_landed", landed, 0);

    // Accumulate, commit only on tick
    repeat (3) strobe(5);
    check("pre_tick_v", mouse_v, 720);
    tick();
    check("commit_v", mouse_v, 870);

    // Saturation and clamping
    repeat (4) strobe(255);
    tick();
    check("clamp_max", mouse_v, 4650);
    repeat (4) strobe(-256);
    tick();
    check("clamp_min", mouse_v, 720);

    // Strobe coincident with tick carries into the next frame
    repeat (3) strobe(1);
    mouse_valid = 1'b1;
    mouse_dy    = 9'd2;
    tick();
    mouse_valid = 1'b0;
    check("coinc_v", mouse_v, 750);
    tick();
    check("carry_v", mouse_v, 770);

    // Catch reel from 900
    strobe(13);
    tick();
    check("pre_catch_v", mouse_v, 900);
    catch_evt = 1'b1;
    step();
    catch_evt = 1'b0;
    check("catch_st", st, 1);
    check("catch_hooked", hooked, 1);
    strobe(5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reel_v", mouse_v, exp_v[i]);
      check("reel_landed", landed, (i == 4) ? 1 : 0);
    end
    check("landed_st", st, 2);
    step();
    check("landed_pulse_end", landed, 0);

    // Landed hold: catch and mouse ignored
    catch_evt = 1'b1;
    step();
    catch_evt = 1'b0;
    strobe(50);
    repeat (29) tick();
    check("land29_st", st, 2);
    check("land29_v", mouse_v, 720);
    tick();
    check("land30_st", st, 0);
    check("land30_hooked", hooked, 0);
    strobe(5);
    tick();
    check("resume_v", mouse_v, 770);

    // Button reel then async reset mid-reel
    reel_btn = 1'b1;
    step();
    check("btn_st", st, 1);
    check("btn_hooked", hooked, 0);
    tick();
    check("btn_reel_v", mouse_v, 730);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_v", mouse_v, 720);
    check("async_rst_st", st, 0);
    reel_btn = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Trigger wins over a coincident tick; reel from MIN_V lands on first tick
    strobe(5);
    reel_btn   = 1'b1;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("trig_win_st", st, 1);
    check("trig_win_v", mouse_v, 720);
    tick();
    check("min_land_st", st, 2);
    check("min_land_pulse", landed, 1);
    reel_btn = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
